// File: rtl/apb_master_ctrl.sv
// APB-side master of the AHB2APB bridge: decodes pipelined AHB requests into a
// one-hot peripheral select and sequences APB SETUP/ENABLE phases.
module apb_master_ctrl #(
  parameter logic [31:0] SLV0_BASE   = 32'h8000_0000,
  parameter logic [31:0] SLV1_BASE   = 32'h8400_0000,
  parameter logic [31:0] SLV2_BASE   = 32'h8800_0000,
  parameter int          REGION_BITS = 26
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        Valid,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic        Hwrite,
  output logic        Hreadyout,
  output logic        Hresp,
  output logic [31:0] Hrdata,
  output logic        Hrvalid,
  input  logic [31:0] Prdata,
  output logic [2:0]  Pselx,
  output logic        Penable,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata,
  output logic        Pwrite
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ENABLE = 2'd2
  } state_t;

  state_t      r_state;
  logic [2:0]  w_sel;
  logic        w_mapped;
  logic        w_accept;

  // Region tags compare only the bits above the 64 MB window.
  assign w_sel[0] = (Haddr[31:REGION_BITS] == SLV0_BASE[31:REGION_BITS]);
  assign w_sel[1] = (Haddr[31:REGION_BITS] == SLV1_BASE[31:REGION_BITS]);
  assign w_sel[2] = (Haddr[31:REGION_BITS] == SLV2_BASE[31:REGION_BITS]);
  assign w_mapped = |w_sel;

  assign Hreadyout = (r_state != ST_SETUP);
  assign w_accept  = Valid & Hreadyout;

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      r_state <= ST_IDLE;
      Pselx   <= '0;
      Penable <= 1'b0;
      Paddr   <= '0;
      Pwdata  <= '0;
      Pwrite  <= 1'b0;
      Hrdata  <= '0;
      Hrvalid <= 1'b0;
      Hresp   <= 1'b0;
    end else begin
      Hrvalid <= 1'b0;
      Hresp   <= 1'b0;

      // Read data is captured on the edge that closes ENABLE, whatever follows.
      if (r_state == ST_ENABLE && !Pwrite) begin
        Hrdata  <= Prdata;
        Hrvalid <= 1'b1;
      end

      case (r_state)
        ST_SETUP: begin
          r_state <= ST_ENABLE;
          Penable <= 1'b1;
        end
        ST_IDLE, ST_ENABLE: begin
          if (w_accept && w_mapped) begin
            r_state <= ST_SETUP;
            Pselx   <= w_sel;
            Penable <= 1'b0;
            Paddr   <= Haddr;
            Pwdata  <= Hwdata;
            Pwrite  <= Hwrite;
          end else begin
            // Unmapped accept or end of transfer: drop select, keep address/data.
            r_state <= ST_IDLE;
            Pselx   <= '0;
            Penable <= 1'b0;
            Hresp   <= w_accept;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          Pselx   <= '0;
          Penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: per-scenario tasks with inline checks,
// plus a scoreboard of expected APB transfers and read returns.
module tb_apb_master_ctrl;

  logic        Hclk;
  logic        Hreset;
  logic        Valid;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic        Hwrite;
  logic        Hreadyout;
  logic        Hresp;
  logic [31:0] Hrdata;
  logic        Hrvalid;
  logic [31:0] Prdata;
  logic [2:0]  Pselx;
  logic        Penable;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic        Pwrite;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
  } apb_t;

  apb_t        apb_q[$];
  logic [31:0] rd_q[$];
  apb_t        apb_e;
  logic [31:0] rd_e;
  logic [31:0] r_key;

  apb_master_ctrl dut (
    .Hclk(Hclk), .Hreset(Hreset), .Valid(Valid), .Haddr(Haddr), .Hwdata(Hwdata),
    .Hwrite(Hwrite), .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata),
    .Hrvalid(Hrvalid), .Prdata(Prdata), .Pselx(Pselx), .Penable(Penable),
    .Paddr(Paddr), .Pwdata(Pwdata), .Pwrite(Pwrite)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  // Slave model: read data only meaningful during the ENABLE phase of a read.
  assign Prdata = (Penable && !Pwrite && Pselx != 3'b000) ? (Paddr ^ r_key) : 32'hDEAD_0000;

  function automatic logic [2:0] exp_sel(input logic [31:0] a);
    logic [5:0] tag;
    tag = a[31:26];
    case (tag)
      6'h20:   exp_sel = 3'b001;
      6'h21:   exp_sel = 3'b010;
      6'h22:   exp_sel = 3'b100;
      default: exp_sel = 3'b000;
    endcase
  endfunction

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic w);
    Valid  = v;
    Haddr  = a;
    Hwdata = d;
    Hwrite = w;
  endtask

  task automatic push_req(input logic [31:0] a, input logic [31:0] d, input logic w);
    apb_t t;
    t.sel  = exp_sel(a);
    t.addr = a;
    t.data = d;
    t.wr   = w;
    apb_q.push_back(t);
    if (!w) rd_q.push_back(a ^ r_key);
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge Hclk) begin
    if (!Hreset) begin
      if (Penable) begin
        n_vec++;
        if (apb_q.size() == 0) begin
          n_err++;
          $display("FAIL apb_xfer: unexpected ENABLE sel=%b addr=%h", Pselx, Paddr);
        end else begin
          apb_e = apb_q.pop_front();
          if (Pselx !== apb_e.sel || Paddr !== apb_e.addr || Pwrite !== apb_e.wr || Pwdata !== apb_e.data) begin
            n_err++;
            $display("FAIL apb_xfer: got sel=%b addr=%h wr=%b wd=%h want sel=%b addr=%h wr=%b wd=%h",
                     Pselx, Paddr, Pwrite, Pwdata, apb_e.sel, apb_e.addr, apb_e.wr, apb_e.data);
          end
        end
      end
      if (Hrvalid) begin
        n_vec++;
        if (rd_q.size() == 0) begin
          n_err++;
          $display("FAIL rd_return: unexpected Hrvalid data=%h", Hrdata);
        end else begin
          rd_e = rd_q.pop_front();
          if (Hrdata !== rd_e) begin
            n_err++;
            $display("FAIL rd_return: got %h want %h", Hrdata, rd_e);
          end
        end
      end
      n_vec++;
      if (!$onehot0(Pselx) || (Pselx != 3'b000 && !Penable && Hreadyout)) begin
        n_err++;
        $display("FAIL apb_invariant: sel=%b penable=%b hreadyout=%b", Pselx, Penable, Hreadyout);
      end
    end
  end

  task automatic test_reset();
    Hreset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    r_key = 32'h0;
    #1;
    n_vec++;
    if ({Pselx, Penable, Paddr, Pwdata, Pwrite, Hrdata, Hrvalid, Hresp} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got sel=%b en=%b addr=%h wd=%h wr=%b rd=%h rv=%b resp=%b want all zero",
               Pselx, Penable, Paddr, Pwdata, Pwrite, Hrdata, Hrvalid, Hresp);
    end
    tick();
    tick();
    Hreset = 1'b0;
    tick();
    n_vec++;
    if ({Hreadyout, Pselx, Penable} !== 5'b1_000_0) begin
      n_err++;
      $display("FAIL reset_release: got rdy=%b sel=%b en=%b want rdy=1 sel=000 en=0", Hreadyout, Pselx, Penable);
    end
  endtask

  task automatic test_single_write();
    drive(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 1'b1);
    push_req(32'h8000_0010, 32'hDEAD_BEEF, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    n_vec++;
    if ({Pselx, Penable, Pwrite, Hreadyout} !== 6'b001_0_1_0 || Paddr !== 32'h8000_0010 || Pwdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL wr_setup: got sel=%b en=%b wr=%b rdy=%b addr=%h wd=%h want 001/0/1/0 80000010 deadbeef",
               Pselx, Penable, Pwrite, Hreadyout, Paddr, Pwdata);
    end
    tick();
    n_vec++;
    if ({Pselx, Penable, Hreadyout} !== 5'b001_1_1) begin
      n_err++;
      $display("FAIL wr_enable: got sel=%b en=%b rdy=%b want 001/1/1", Pselx, Penable, Hreadyout);
    end
    tick();
    n_vec++;
    if ({Pselx, Penable, Hrvalid} !== 5'b000_0_0 || Paddr !== 32'h8000_0010 || Hrdata !== 32'h0) begin
      n_err++;
      $display("FAIL wr_idle: got sel=%b en=%b rv=%b addr=%h rd=%h want 000/0/0 80000010 00000000",
               Pselx, Penable, Hrvalid, Paddr, Hrdata);
    end
    tick();
    n_vec++;
    if (Hrvalid !== 1'b0) begin
      n_err++;
      $display("FAIL wr_no_rvalid: got %b want 0", Hrvalid);
    end
  endtask

  task automatic test_single_read();
    r_key = 32'h9634_567C;  // makes the slave return 32'h1234_5678 for 32'h8400_0004
    drive(1'b1, 32'h8400_0004, 32'h0BAD_F00D, 1'b0);
    push_req(32'h8400_0004, 32'h0BAD_F00D, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    n_vec++;
    if ({Pselx, Penable, Pwrite, Hrvalid} !== 6'b010_0_0_0) begin
      n_err++;
      $display("FAIL rd_setup: got sel=%b en=%b wr=%b rv=%b want 010/0/0/0", Pselx, Penable, Pwrite, Hrvalid);
    end
    tick();
    n_vec++;
    if ({Pselx, Penable, Hrvalid} !== 5'b010_1_0) begin
      n_err++;
      $display("FAIL rd_enable: got sel=%b en=%b rv=%b want 010/1/0", Pselx, Penable, Hrvalid);
    end
    tick();
    n_vec++;
    if (Hrvalid !== 1'b1 || Hrdata !== 32'h1234_5678 || Pselx !== 3'b000) begin
      n_err++;
      $display("FAIL rd_return_cycle: got rv=%b rd=%h sel=%b want 1 12345678 000", Hrvalid, Hrdata, Pselx);
    end
    tick();
    n_vec++;
    if (Hrvalid !== 1'b0 || Hrdata !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL rd_after: got rv=%b rd=%h want 0 12345678", Hrvalid, Hrdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a[3];
    logic [31:0] d[3];
    logic        w[3];
    logic [2:0]  s[3];
    a = '{32'h8800_0000, 32'h8000_0008, 32'h8400_0000};
    d = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    w = '{1'b1, 1'b0, 1'b1};
    s = '{3'b100, 3'b001, 3'b010};
    r_key = 32'hA5A5_0F0F;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (Hreadyout !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_ready_%0d: got %b want 1", i, Hreadyout);
      end
      drive(1'b1, a[i], d[i], w[i]);
      push_req(a[i], d[i], w[i]);
      tick();
      n_vec++;
      if ({Pselx, Penable, Hreadyout} !== {s[i], 2'b00}) begin
        n_err++;
        $display("FAIL b2b_setup_%0d: got sel=%b en=%b rdy=%b want %b/0/0", i, Pselx, Penable, Hreadyout, s[i]);
      end
      // Next request is presented during SETUP but must not be taken until ENABLE.
      if (i < 2) drive(1'b1, a[i+1], d[i+1], w[i+1]);
      else       drive(1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      n_vec++;
      if ({Pselx, Penable} !== {s[i], 1'b1}) begin
        n_err++;
        $display("FAIL b2b_enable_%0d: got sel=%b en=%b want %b/1", i, Pselx, Penable, s[i]);
      end
    end
    n_vec++;
    if (Hreadyout !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_ready_end: got %b want 1", Hreadyout);
    end
    tick();
    n_vec++;
    if ({Pselx, Penable} !== 4'b000_0) begin
      n_err++;
      $display("FAIL b2b_idle: got sel=%b en=%b want 000/0", Pselx, Penable);
    end
  endtask

  task automatic test_unmapped();
    drive(1'b1, 32'h0000_1000, 32'h0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    n_vec++;
    if ({Hresp, Pselx, Penable, Hrvalid, Hreadyout} !== 7'b1_000_0_0_1) begin
      n_err++;
      $display("FAIL unmapped_resp: got resp=%b sel=%b en=%b rv=%b rdy=%b want 1/000/0/0/1",
               Hresp, Pselx, Penable, Hrvalid, Hreadyout);
    end
    tick();
    n_vec++;
    if ({Hresp, Pselx, Penable, Hrvalid} !== 6'b0_000_0_0) begin
      n_err++;
      $display("FAIL unmapped_after: got resp=%b sel=%b en=%b rv=%b want 0/000/0/0", Hresp, Pselx, Penable, Hrvalid);
    end
  endtask

  task automatic test_decode_edges();
    logic [31:0] a[7];
    logic [2:0]  sel;
    logic        wr;
    a = '{32'h7FFF_FFFC, 32'h8000_0000, 32'h83FF_FFFC, 32'h8400_0000,
          32'h87FF_FFFF, 32'h8BFF_FFFC, 32'h8C00_0000};
    r_key = 32'h3C3C_C3C3;
    for (int i = 0; i < 7; i++) begin
      sel = exp_sel(a[i]);
      wr  = (i % 2) == 1;
      drive(1'b1, a[i], ~a[i], wr);
      if (sel != 3'b000) push_req(a[i], ~a[i], wr);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      n_vec++;
      if ({Pselx, Hresp} !== {sel, sel == 3'b000}) begin
        n_err++;
        $display("FAIL decode_%h: got sel=%b resp=%b want %b/%b", a[i], Pselx, Hresp, sel, sel == 3'b000);
      end
      if (sel != 3'b000) begin
        tick();
        tick();
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_reset_mid_read();
    r_key = 32'h0F0F_0F0F;
    drive(1'b1, 32'h8000_0020, 32'h0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    n_vec++;
    if (Penable !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_enable: got en=%b want 1", Penable);
    end
    #1;
    Hreset = 1'b1;
    #1;
    n_vec++;
    if ({Pselx, Penable, Hrvalid} !== 5'b000_0_0) begin
      n_err++;
      $display("FAIL rst_mid_async: got sel=%b en=%b rv=%b want 000/0/0", Pselx, Penable, Hrvalid);
    end
    tick();
    Hreset = 1'b0;
    tick();
    n_vec++;
    if ({Hreadyout, Pselx, Penable, Hrvalid} !== 6'b1_000_0_0) begin
      n_err++;
      $display("FAIL rst_mid_release: got rdy=%b sel=%b en=%b rv=%b want 1/000/0/0", Hreadyout, Pselx, Penable, Hrvalid);
    end
  endtask

  task automatic test_unmapped_in_enable();
    r_key = 32'h5555_AAAA;
    drive(1'b1, 32'h8000_0000, 32'h7777_7777, 1'b0);
    push_req(32'h8000_0000, 32'h7777_7777, 1'b0);
    tick();
    drive(1'b1, 32'h0000_2000, 32'h0, 1'b0);
    tick();
    n_vec++;
    if ({Penable, Hreadyout, Hresp} !== 3'b1_1_0) begin
      n_err++;
      $display("FAIL unm_en_enable: got en=%b rdy=%b resp=%b want 1/1/0", Penable, Hreadyout, Hresp);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    n_vec++;
    if ({Hrvalid, Hresp, Pselx, Penable} !== 6'b1_1_000_0 || Hrdata !== (32'h8000_0000 ^ 32'h5555_AAAA)) begin
      n_err++;
      $display("FAIL unm_en_pulse: got rv=%b resp=%b sel=%b en=%b rd=%h want 1/1/000/0 %h",
               Hrvalid, Hresp, Pselx, Penable, Hrdata, 32'h8000_0000 ^ 32'h5555_AAAA);
    end
    tick();
    n_vec++;
    if ({Hrvalid, Hresp, Pselx, Penable, Hreadyout} !== 7'b0_0_000_0_1) begin
      n_err++;
      $display("FAIL unm_en_idle: got rv=%b resp=%b sel=%b en=%b rdy=%b want 0/0/000/0/1",
               Hrvalid, Hresp, Pselx, Penable, Hreadyout);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_unmapped();
    test_decode_edges();
    test_reset_mid_read();
    test_unmapped_in_enable();
    tick();
    tick();
    n_vec++;
    if (apb_q.size() != 0 || rd_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d apb / %0d read entries left want 0/0", apb_q.size(), rd_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
